// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM bus between instruction fetch and the MEM stage.
// One bus transaction is in flight at a time. Every output except stall_req
// is registered. A watchdog timer aborts a transaction the bus never acks.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    // data (MEM stage) side
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    // SRAM bus side
    output logic              bus_req,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    // status
    output logic              timeout_o,
    output logic              stall_req
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, DONE} state_t;
    typedef enum logic {GRANT_IF, GRANT_MEM} grant_t;

    // Timer counts 0 .. TIMEOUT-1 inside a busy state.
    localparam int            TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t              state_q,      state_d;
    grant_t              last_grant_q, last_grant_d;
    logic [TW-1:0]       timer_q,      timer_d;
    logic                bus_req_q,    bus_req_d;
    logic                bus_we_q,     bus_we_d;
    logic [3:0]          bus_sel_q,    bus_sel_d;
    logic [ADDR_W-1:0]   bus_addr_q,   bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q,  bus_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q,  mem_rdata_d;
    logic                if_ack_q,     if_ack_d;
    logic                mem_ack_q,    mem_ack_d;
    logic                timeout_q,    timeout_d;
    logic                grant_mem;

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; a missing default here would infer a latch.
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_sel_d    = bus_sel_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ack_d     = 1'b0;
        mem_ack_d    = 1'b0;
        timeout_d    = 1'b0;
        grant_mem    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Under contention MEM wins unless it won the previous round.
                if (if_req && mem_req) grant_mem = (last_grant_q != GRANT_MEM);
                else                   grant_mem = mem_req;

                if (if_req || mem_req) begin
                    bus_req_d = 1'b1;
                    timer_d   = '0;
                    if (grant_mem) begin
                        bus_we_d    = mem_we;
                        bus_sel_d   = mem_sel;
                        bus_addr_d  = mem_addr;
                        bus_wdata_d = mem_wdata;
                        state_d     = MEM_BUSY;
                    end else begin
                        bus_we_d    = 1'b0;
                        bus_sel_d   = 4'b1111;
                        bus_addr_d  = if_addr;
                        bus_wdata_d = '0;
                        state_d     = IF_BUSY;
                    end
                end
            end

            IF_BUSY, MEM_BUSY: begin
                timer_d = timer_q + 1'b1;
                if (bus_ack) begin
                    // A late ack on the last timer cycle still completes normally.
                    bus_req_d = 1'b0;
                    state_d   = DONE;
                    if (state_q == IF_BUSY) begin
                        if_rdata_d   = bus_rdata;
                        if_ack_d     = 1'b1;
                        last_grant_d = GRANT_IF;
                    end else begin
                        if (!bus_we_q) mem_rdata_d = bus_rdata;
                        mem_ack_d    = 1'b1;
                        last_grant_d = GRANT_MEM;
                    end
                end else if (timer_q == T_LAST) begin
                    // Abort: the requester still gets its ack, flagged by timeout_o.
                    bus_req_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                    if (state_q == IF_BUSY) begin
                        if_rdata_d = '0;
                        if_ack_d   = 1'b1;
                    end else begin
                        mem_rdata_d = '0;
                        mem_ack_d   = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            timer_q      <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ack_q     <= 1'b0;
            mem_ack_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ack_q     <= if_ack_d;
            mem_ack_q    <= mem_ack_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign timeout_o = timeout_q;

    // Pipeline stall: any requester still waiting for its ack.
    assign stall_req = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Two instances share all inputs: "dut" uses
// the default timeout, "dut_t" uses TIMEOUT=4 for the watchdog scenarios.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ack, mem_ack, bus_req, bus_we, timeout_o, stall_req;
    logic [3:0]  bus_sel;

    logic [31:0] t_if_rdata, t_mem_rdata, t_bus_addr, t_bus_wdata;
    logic        t_if_ack, t_mem_ack, t_bus_req, t_bus_we, t_timeout_o, t_stall_req;
    logic [3:0]  t_bus_sel;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .timeout_o(timeout_o), .stall_req(stall_req)
    );

    mem_arbiter #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(t_if_rdata), .if_ack(t_if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(t_mem_rdata), .mem_ack(t_mem_ack),
        .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_sel(t_bus_sel), .bus_addr(t_bus_addr),
        .bus_wdata(t_bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .timeout_o(t_timeout_o), .stall_req(t_stall_req)
    );

    // Advance one cycle; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; bus_ack = 1'b0;
        if_addr = '0; mem_addr = '0; mem_sel = '0; mem_wdata = '0; bus_rdata = '0;
        tick(); tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus_req !== 1'b0) $display("FAIL reset_bus_req got=%0h exp=0", bus_req); else passed++;
        total++; if (bus_sel !== 4'h0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_we !== 1'b0)
            $display("FAIL reset_bus_fields got sel=%0h addr=%0h wdata=%0h we=%0h exp=0", bus_sel, bus_addr, bus_wdata, bus_we);
        else passed++;
        total++; if ({if_ack, mem_ack, timeout_o, stall_req} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {if_ack, mem_ack, timeout_o, stall_req}); else passed++;
        total++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) $display("FAIL reset_rdata got if=%0h mem=%0h exp=0", if_rdata, mem_rdata); else passed++;
    endtask

    task automatic test_if_read();
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        total++; if (stall_req !== 1'b1) $display("FAIL if_read_stall_wait got=%0h exp=1", stall_req); else passed++;
        tick();
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_sel !== 4'hF || bus_we !== 1'b0 || bus_wdata !== 32'h0)
            $display("FAIL if_read_bus got req=%0h addr=%0h sel=%0h we=%0h wdata=%0h exp 1/100/f/0/0", bus_req, bus_addr, bus_sel, bus_we, bus_wdata);
        else passed++;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_ack = 1'b0;
        total++; if (if_ack !== 1'b1 || mem_ack !== 1'b0 || timeout_o !== 1'b0) $display("FAIL if_read_ack got if=%0h mem=%0h to=%0h exp 1/0/0", if_ack, mem_ack, timeout_o); else passed++;
        total++; if (if_rdata !== 32'hDEADBEEF) $display("FAIL if_read_rdata got=%0h exp=deadbeef", if_rdata); else passed++;
        total++; if (stall_req !== 1'b0 || bus_req !== 1'b0) $display("FAIL if_read_done got stall=%0h bus_req=%0h exp 0/0", stall_req, bus_req); else passed++;
        if_req = 1'b0;
        tick();
        total++; if (if_ack !== 1'b0) $display("FAIL if_read_ack_pulse got=%0h exp=0", if_ack); else passed++;
    endtask

    task automatic test_contention();
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200;
        tick();
        total++; if (bus_addr !== 32'h200 || bus_we !== 1'b0) $display("FAIL contend_first got addr=%0h we=%0h exp 200/0", bus_addr, bus_we); else passed++;
        bus_ack = 1'b1; bus_rdata = 32'h22222222;
        tick();
        bus_ack = 1'b0;
        total++; if (mem_ack !== 1'b1 || if_ack !== 1'b0 || mem_rdata !== 32'h22222222)
            $display("FAIL contend_mem_done got mem_ack=%0h if_ack=%0h rdata=%0h exp 1/0/22222222", mem_ack, if_ack, mem_rdata);
        else passed++;
        total++; if (stall_req !== 1'b1) $display("FAIL contend_if_stall got=%0h exp=1", stall_req); else passed++;
        mem_req = 1'b0;
        tick();
        tick();
        total++; if (bus_addr !== 32'h100 || bus_sel !== 4'hF || bus_req !== 1'b1) $display("FAIL contend_second got addr=%0h sel=%0h req=%0h exp 100/f/1", bus_addr, bus_sel, bus_req); else passed++;
        bus_ack = 1'b1; bus_rdata = 32'h11111111;
        tick();
        bus_ack = 1'b0;
        total++; if (if_ack !== 1'b1 || if_rdata !== 32'h11111111) $display("FAIL contend_if_done got ack=%0h rdata=%0h exp 1/11111111", if_ack, if_rdata); else passed++;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_alternation();
        logic [31:0] exp_addr;
        do_reset();
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            exp_addr = (k % 2 == 0) ? 32'h200 : 32'h100;
            tick();
            total++; if (bus_addr !== exp_addr) $display("FAIL alternate_grant%0d got=%0h exp=%0h", k, bus_addr, exp_addr); else passed++;
            bus_ack = 1'b1; bus_rdata = 32'h1000 + k;
            tick();
            bus_ack = 1'b0;
            total++; if ({mem_ack, if_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL alternate_ack%0d got mem=%0h if=%0h", k, mem_ack, if_ack);
            else passed++;
            tick();
        end
        if_req = 1'b0; mem_req = 1'b0;
        tick();
    endtask

    task automatic test_mem_write();
        do_reset();
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h40;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ack = 1'b0; mem_req = 1'b0;
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h80; mem_wdata = 32'h1234;
        tick();
        mem_req = 1'b1; mem_addr = 32'hFFFF; mem_wdata = 32'hBAD;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_sel !== 4'b0011 || bus_addr !== 32'h80 || bus_wdata !== 32'h1234)
                $display("FAIL write_hold%0d got req=%0h we=%0h sel=%0h addr=%0h wdata=%0h exp 1/1/3/80/1234", i, bus_req, bus_we, bus_sel, bus_addr, bus_wdata);
            else passed++;
            if (i == 4) begin bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF; end
            tick();
        end
        bus_ack = 1'b0;
        total++; if (mem_ack !== 1'b1 || if_ack !== 1'b0 || timeout_o !== 1'b0) $display("FAIL write_ack got mem=%0h if=%0h to=%0h exp 1/0/0", mem_ack, if_ack, timeout_o); else passed++;
        total++; if (mem_rdata !== 32'hCAFEF00D) $display("FAIL write_rdata_kept got=%0h exp=cafef00d", mem_rdata); else passed++;
        mem_req = 1'b0;
        tick();
        total++; if (mem_ack !== 1'b0) $display("FAIL write_ack_pulse got=%0h exp=0", mem_ack); else passed++;
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h40;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hAAAA5555;
        tick();
        bus_ack = 1'b0; mem_req = 1'b0;
        tick();
        total++; if (t_mem_rdata !== 32'hAAAA5555) $display("FAIL timeout_preload got=%0h exp=aaaa5555", t_mem_rdata); else passed++;
        mem_req = 1'b1; mem_addr = 32'h300;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++; if (t_bus_req !== 1'b1 || t_mem_ack !== 1'b0) $display("FAIL timeout_busy%0d got req=%0h ack=%0h exp 1/0", i, t_bus_req, t_mem_ack); else passed++;
            tick();
        end
        total++; if (t_bus_req !== 1'b0) $display("FAIL timeout_bus_drop got=%0h exp=0", t_bus_req); else passed++;
        total++; if (t_mem_ack !== 1'b1 || t_timeout_o !== 1'b1 || t_if_ack !== 1'b0) $display("FAIL timeout_flags got ack=%0h to=%0h if=%0h exp 1/1/0", t_mem_ack, t_timeout_o, t_if_ack); else passed++;
        total++; if (t_mem_rdata !== 32'h0) $display("FAIL timeout_rdata got=%0h exp=0", t_mem_rdata); else passed++;
        mem_req = 1'b0;
        tick();
        total++; if (t_timeout_o !== 1'b0 || t_mem_ack !== 1'b0) $display("FAIL timeout_pulse got to=%0h ack=%0h exp 0/0", t_timeout_o, t_mem_ack); else passed++;
        mem_req = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin bus_ack = 1'b1; bus_rdata = 32'h00005A5A; end
            tick();
        end
        bus_ack = 1'b0;
        total++; if (t_mem_ack !== 1'b1 || t_timeout_o !== 1'b0 || t_mem_rdata !== 32'h00005A5A)
            $display("FAIL timeout_late_ack got ack=%0h to=%0h rdata=%0h exp 1/0/5a5a", t_mem_ack, t_timeout_o, t_mem_rdata);
        else passed++;
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h40;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h77;
        tick();
        bus_ack = 1'b0; mem_req = 1'b0;
        tick();
        mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'h5; mem_addr = 32'h600; mem_wdata = 32'h99;
        tick();
        tick();
        total++; if (bus_req !== 1'b1 || mem_rdata !== 32'h77) $display("FAIL midreset_pre got req=%0h rdata=%0h exp 1/77", bus_req, mem_rdata); else passed++;
        rst = 1'b0; mem_req = 1'b0;
        tick();
        rst = 1'b1;
        total++; if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== '0) $display("FAIL midreset_bus got req=%0h we=%0h sel=%0h addr=%0h wdata=%0h exp 0", bus_req, bus_we, bus_sel, bus_addr, bus_wdata); else passed++;
        total++; if ({if_ack, mem_ack, timeout_o, stall_req} !== 4'b0 || mem_rdata !== 32'h0 || if_rdata !== 32'h0)
            $display("FAIL midreset_out got flags=%b mem_rdata=%0h if_rdata=%0h exp 0", {if_ack, mem_ack, timeout_o, stall_req}, mem_rdata, if_rdata);
        else passed++;
        bus_ack = 1'b1; bus_rdata = 32'h1;
        tick();
        bus_ack = 1'b0;
        tick();
        total++; if (mem_ack !== 1'b0 || if_ack !== 1'b0 || bus_req !== 1'b0) $display("FAIL midreset_stray got mem=%0h if=%0h req=%0h exp 0/0/0", mem_ack, if_ack, bus_req); else passed++;
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h500) $display("FAIL midreset_fresh_grant got req=%0h addr=%0h exp 1/500", bus_req, bus_addr); else passed++;
        bus_ack = 1'b1; bus_rdata = 32'h0BADC0DE;
        tick();
        bus_ack = 1'b0;
        total++; if (if_ack !== 1'b1 || if_rdata !== 32'h0BADC0DE) $display("FAIL midreset_fresh_ack got ack=%0h rdata=%0h exp 1/badc0de", if_ack, if_rdata); else passed++;
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_contention();
        test_alternation();
        test_mem_write();
        test_timeout();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
